// File: rtl/motor_frame_decoder_pkg.sv
// MCPkg: frame layout, decoder state encoding and small helpers shared by the
// motor frame decoder and its command FIFO.
package MCPkg;

    localparam logic [7:0] MOTOR_FRAME_HEADER = 8'hA5;
    localparam int         MOTOR_CMD_W        = 44;   // motor + flags + payload

    typedef struct packed {
        logic clk;
        logic reset;
    } ClkRs_t;

    typedef struct packed {
        logic [7:0]  header;
        logic [3:0]  seq;
        logic [3:0]  motor;
        logic [7:0]  checksum;
        logic [7:0]  flags;
        logic [31:0] payload;
    } motor_frame_t;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_VERIFY,
        ST_LOCKED
    } dec_state_e;

    function automatic logic [7:0] frame_checksum(input motor_frame_t f);
        return {f.seq, f.motor} ^ f.flags ^ f.payload[31:24] ^ f.payload[23:16]
             ^ f.payload[15:8] ^ f.payload[7:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/motor_cmd_fifo.sv
// Single-clock command FIFO with synchronous reset; head word is presented
// combinationally and reads as zero while empty. DEPTH must be a power of two >= 2.
module motor_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 44
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/motor_frame_decoder.sv
// Motor command frame decoder: header lock FSM, watchdog, sequence/overflow
// accounting and command FIFO. Define MOTOR_FRAME_CHECKSUM_EN to drop bad-checksum frames.
module motor_frame_decoder
    import MCPkg::*;
#(
    parameter int g_lock_count   = 4,
    parameter int g_unlock_count = 3,
    parameter int g_timeout      = 1024,
    parameter int g_fifo_depth   = 4
) (
    input  ClkRs_t      ClkRs_ix,
    input  logic [63:0] data_ib64,
    input  logic        data_valid_i,
    input  logic        cmd_ready_i,
    output logic        cmd_valid_o,
    output logic [3:0]  cmd_motor_ob4,
    output logic [7:0]  cmd_flags_ob8,
    output logic [31:0] cmd_data_ob32,
    output logic        locked_o,
    output logic        timeout_o,
    output logic [15:0] seq_err_ob16,
    output logic [15:0] chk_err_ob16,
    output logic [15:0] ovf_err_ob16
);
    localparam int LCW = $clog2(g_lock_count + 1);
    localparam int UCW = $clog2(g_unlock_count + 1);
    localparam int WDW = $clog2(g_timeout + 1);

    logic clk, rst;
    assign clk = ClkRs_ix.clk;
    assign rst = ClkRs_ix.reset;

    motor_frame_t     frame_q;
    logic             vld_q;
    dec_state_e       state_q, state_d;
    logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [UCW-1:0]   bad_cnt_q, bad_cnt_d;
    logic [WDW-1:0]   wd_q, wd_d;
    logic             have_ref_q, have_ref_d;
    logic [3:0]       prev_seq_q, prev_seq_d;
    logic             timeout_q, timeout_d;
    logic [15:0]      seq_err_q, seq_err_d;
    logic [15:0]      chk_err_q, chk_err_d;
    logic [15:0]      ovf_err_q, ovf_err_d;
    logic             good_hdr, bad_hdr, chk_ok, push_req, pop;
    logic             fifo_full, fifo_empty;
    logic [MOTOR_CMD_W-1:0] fifo_dout;

    // Input stage: frame data is not reset; only its valid qualifier is.
    // cmd_ready_i is used directly so the pop matches the handshake seen on the port.
    always_ff @(posedge clk) begin
        frame_q <= data_ib64;
        if (rst) vld_q <= 1'b0;
        else     vld_q <= data_valid_i;
    end

`ifdef MOTOR_FRAME_CHECKSUM_EN
    assign chk_ok = (frame_checksum(frame_q) == frame_q.checksum);
`else
    logic unused_checksum;
    assign unused_checksum = ^frame_q.checksum;
    assign chk_ok          = 1'b1;
`endif

    assign good_hdr = vld_q && (frame_q.header == MOTOR_FRAME_HEADER);
    assign bad_hdr  = vld_q && (frame_q.header != MOTOR_FRAME_HEADER);
    assign pop      = cmd_valid_o && cmd_ready_i;

    // Decode stage: lock FSM, watchdog and counter updates on the registered frame.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        wd_d       = wd_q;
        have_ref_d = have_ref_q;
        prev_seq_d = prev_seq_q;
        timeout_d  = 1'b0;
        seq_err_d  = seq_err_q;
        chk_err_d  = chk_err_q;
        push_req   = 1'b0;

        case (state_q)
            ST_HUNT: begin
                lock_cnt_d = '0;
                bad_cnt_d  = '0;
                wd_d       = '0;
                have_ref_d = 1'b0;
                if (good_hdr) begin
                    if (g_lock_count <= 1) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d    = ST_VERIFY;
                        lock_cnt_d = LCW'(1);
                    end
                end
            end
            ST_VERIFY: begin
                bad_cnt_d  = '0;
                wd_d       = '0;
                have_ref_d = 1'b0;
                if (good_hdr) begin
                    if (int'(lock_cnt_q) + 1 >= g_lock_count) state_d = ST_LOCKED;
                    else                                      lock_cnt_d = lock_cnt_q + LCW'(1);
                end else if (bad_hdr) begin
                    state_d    = ST_HUNT;
                    lock_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                wd_d = vld_q ? '0 : wd_q + WDW'(1);
                if (good_hdr) begin
                    bad_cnt_d  = '0;
                    have_ref_d = 1'b1;
                    prev_seq_d = frame_q.seq;
                    if (have_ref_q && (frame_q.seq != prev_seq_q + 4'd1))
                        seq_err_d = sat_inc16(seq_err_q);
                    if (chk_ok) push_req  = 1'b1;
                    else        chk_err_d = sat_inc16(chk_err_q);
                end else if (bad_hdr) begin
                    if (int'(bad_cnt_q) + 1 >= g_unlock_count) state_d = ST_HUNT;
                    else                                        bad_cnt_d = bad_cnt_q + UCW'(1);
                end else if (int'(wd_q) + 1 >= g_timeout) begin
                    state_d   = ST_HUNT;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_HUNT;
        endcase

        ovf_err_d = (push_req && fifo_full && !pop) ? sat_inc16(ovf_err_q) : ovf_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            lock_cnt_q <= '0;
            bad_cnt_q  <= '0;
            wd_q       <= '0;
            have_ref_q <= 1'b0;
            prev_seq_q <= '0;
            timeout_q  <= 1'b0;
            seq_err_q  <= '0;
            chk_err_q  <= '0;
            ovf_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            wd_q       <= wd_d;
            have_ref_q <= have_ref_d;
            prev_seq_q <= prev_seq_d;
            timeout_q  <= timeout_d;
            seq_err_q  <= seq_err_d;
            chk_err_q  <= chk_err_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

    // Output stage: FIFO holds decoded commands and survives loss of lock.
    motor_cmd_fifo #(
        .DEPTH (g_fifo_depth),
        .WIDTH (MOTOR_CMD_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .data_i  ({frame_q.motor, frame_q.flags, frame_q.payload}),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cmd_valid_o = !fifo_empty;
    assign {cmd_motor_ob4, cmd_flags_ob8, cmd_data_ob32} = fifo_dout;
    assign locked_o     = (state_q == ST_LOCKED);
    assign timeout_o    = timeout_q;
    assign seq_err_ob16 = seq_err_q;
    assign chk_err_ob16 = chk_err_q;
    assign ovf_err_ob16 = ovf_err_q;

endmodule

// File: tb/tb_motor_frame_decoder.sv
// Scoreboard bench for motor_frame_decoder: expected commands are queued as frames
// are driven and compared as the decoder hands them out.
module tb_motor_frame_decoder;
    import MCPkg::*;

    logic        clk = 1'b0;
    logic        rst;
    ClkRs_t      clk_rs;
    logic [63:0] data;
    logic        data_valid;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [3:0]  cmd_motor;
    logic [7:0]  cmd_flags;
    logic [31:0] cmd_data;
    logic        locked, timeout;
    logic [15:0] seq_err, chk_err, ovf_err;

    logic [43:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_tmo = 0;
    int          tmo_base;

    assign clk_rs = {clk, rst};
    always #5 clk = ~clk;

    motor_frame_decoder dut (
        .ClkRs_ix      (clk_rs),
        .data_ib64     (data),
        .data_valid_i  (data_valid),
        .cmd_ready_i   (cmd_ready),
        .cmd_valid_o   (cmd_valid),
        .cmd_motor_ob4 (cmd_motor),
        .cmd_flags_ob8 (cmd_flags),
        .cmd_data_ob32 (cmd_data),
        .locked_o      (locked),
        .timeout_o     (timeout),
        .seq_err_ob16  (seq_err),
        .chk_err_ob16  (chk_err),
        .ovf_err_ob16  (ovf_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [3:0] seq, input logic [3:0] motor,
                                       input logic [7:0] flags, input logic [31:0] pl,
                                       input logic [7:0] hdr);
        logic [7:0] cs;
        cs = {seq, motor} ^ flags ^ pl[31:24] ^ pl[23:16] ^ pl[15:8] ^ pl[7:0];
        return {hdr, seq, motor, cs, flags, pl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        data_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [63:0] f);
        data       = f;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic send_good(input logic [3:0] seq, input logic [3:0] motor,
                             input logic [7:0] flags, input logic [31:0] pl, input bit pushed);
        if (pushed) exp_q.push_back({motor, flags, pl});
        send_frame(mk(seq, motor, flags, pl, 8'hA5));
    endtask

    task automatic lock_up();
        for (int i = 0; i < 4; i++) send_good(4'(i), 4'd0, 8'h00, 32'h0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (timeout) n_tmo++;
        if (cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) check("unexpected_cmd", cmd_valid, 1'b0);
            else check("cmd", {cmd_motor, cmd_flags, cmd_data}, exp_q.pop_front());
        end
    end

    initial begin
        logic [63:0] f;
        rst = 1'b1; data = '0; data_valid = 1'b0; cmd_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", cmd_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_timeout", timeout, 0);
        check("rst_counters", {seq_err, chk_err, ovf_err}, 0);
        check("rst_data", {cmd_motor, cmd_flags, cmd_data}, 0);
        rst = 1'b0;
        tick();

        // Lock on four good headers, then the first command with two-cycle latency.
        send_good(0, 0, 0, 0, 0); send_good(1, 0, 0, 0, 0); send_good(2, 0, 0, 0, 0);
        idle(2);
        check("not_locked_3", locked, 0);
        send_good(3, 0, 0, 0, 0);
        idle(1);
        check("locked_4", locked, 1);
        check("lock_frames_not_pushed", cmd_valid, 0);
        send_good(4, 3, 8'h00, 32'h12345678, 1);
        check("lat_n1", cmd_valid, 0);
        tick();
        check("lat_n2", cmd_valid, 1);
        check("lat_data", {cmd_motor, cmd_data}, {4'd3, 32'h12345678});
        idle(2);

        // Sequence gap 6 -> 8.
        send_good(5, 1, 8'h11, 32'hAAAA0005, 1);
        send_good(6, 2, 8'h22, 32'hBBBB0006, 1);
        send_good(8, 4, 8'h44, 32'hCCCC0008, 1);
        idle(3);
        check("seq_err", seq_err, 1);

        // Overflow with consumer stalled.
        cmd_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            send_good(4'(9 + i), 4'(i), 8'(8'h50 + i), 32'(32'hD0000000 + i), i < 4);
        idle(2);
        check("ovf_err", ovf_err, 2);
        check("ovf_valid", cmd_valid, 1);
        check("head_hold", {cmd_motor, cmd_flags, cmd_data}, exp_q[0]);
        idle(3);
        check("head_hold2", {cmd_motor, cmd_flags, cmd_data}, exp_q[0]);
        cmd_ready = 1'b1;
        idle(6);
        check("drained", cmd_valid, 0);
        check("drained_sb", exp_q.size(), 0);

        // Two bad headers then a good one keep lock; three bad drop it.
        send_frame(mk(0, 0, 0, 0, 8'h00));
        send_frame(mk(0, 0, 0, 0, 8'h00));
        send_good(15, 5, 8'h0F, 32'h0000000F, 1);
        idle(2);
        check("bad2_locked", locked, 1);
        repeat (3) send_frame(mk(0, 0, 0, 0, 8'h00));
        idle(2);
        check("bad3_unlocked", locked, 0);
        check("seq_err_keep", seq_err, 1);

        // Relock; checksum-corrupted frame in the middle.
        lock_up();
        send_good(4, 6, 8'h01, 32'h00000104, 1);
        f = mk(5, 7, 8'h02, 32'h00000105, 8'hA5);
        f[47:40] = ~f[47:40];
`ifndef MOTOR_FRAME_CHECKSUM_EN
        exp_q.push_back({4'd7, 8'h02, 32'h00000105});
`endif
        send_frame(f);
        send_good(6, 8, 8'h03, 32'h00000106, 1);
        idle(1023);
`ifdef MOTOR_FRAME_CHECKSUM_EN
        check("chk_err", chk_err, 1);
`else
        check("chk_err", chk_err, 0);
`endif
        check("seq_err_chk", seq_err, 1);

        // Watchdog: 1023 idle cycles are tolerated, 1024 expire.
        tmo_base = n_tmo;
        send_good(7, 9, 8'h04, 32'h00000107, 1);
        idle(3);
        check("no_tmo_1023", n_tmo - tmo_base, 0);
        check("locked_1023", locked, 1);
        idle(1021);
        check("no_tmo_yet", n_tmo - tmo_base, 0);
        check("locked_edge", locked, 1);
        idle(3);
        check("tmo_pulse", n_tmo - tmo_base, 1);
        check("tmo_unlocked", locked, 0);
        check("tmo_sb", exp_q.size(), 0);

        // Reset mid-operation discards queued and in-flight commands.
        cmd_ready = 1'b0;
        lock_up();
        send_good(4, 1, 8'h00, 32'h1, 0);
        send_good(5, 2, 8'h00, 32'h2, 0);
        check("pre_rst_valid", cmd_valid, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", cmd_valid, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_counters", {seq_err, chk_err, ovf_err}, 0);
        rst = 1'b0;
        idle(3);
        check("post_rst_valid", cmd_valid, 0);
        cmd_ready = 1'b1;
        idle(2);
        check("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/motor_frame_decoder.md
MOTOR_FRAME_DECODER -- requirements
Module: motor_frame_decoder

Interface
REQ-001 Parameter g_lock_count, default 4: consecutive good headers needed to reach LOCKED.
REQ-002 Parameter g_unlock_count, default 3: consecutive bad headers in LOCKED before returning to HUNT.
REQ-003 Parameter g_timeout, default 1024: cycles without data_valid_i in LOCKED before timeout.
REQ-004 Parameter g_fifo_depth, default 4, power of two: output command FIFO depth.
REQ-005 ClkRs_ix.clk  in  1  sole clock; GBT RX frame clock domain.
REQ-006 ClkRs_ix.reset  in  1  synchronous, active-high reset.
REQ-007 data_ib64  in  64  received motor_data_b64 word from the GBT link.
REQ-008 data_valid_i  in  1  data_ib64 holds a new frame this cycle.
REQ-009 cmd_ready_i  in  1  consumer accepts the head command.
REQ-010 cmd_valid_o  out  1  command available.
REQ-011 cmd_motor_ob4 / cmd_flags_ob8 / cmd_data_ob32  out  4/8/32  motor index, flags, payload.
REQ-012 locked_o  out  1  decoder in LOCKED.
REQ-013 timeout_o  out  1  one-cycle pulse on watchdog expiry.
REQ-014 seq_err_ob16 / chk_err_ob16 / ovf_err_ob16  out  16 each  saturating error counters.

Function
REQ-015 Frame layout: [63:56] header (0xA5), [55:52] seq, [51:48] motor, [47:40] checksum, [39:32] flags, [31:0] payload.
REQ-016 Checksum = XOR of bytes [55:48], [39:32], [31:24], [23:16], [15:8], [7:0].
REQ-017 All inputs registered once; decode acts on the registered frame.
REQ-018 States: HUNT, VERIFY, LOCKED; good header = registered valid with header 0xA5.
REQ-019 HUNT: good header -> VERIFY with count=1; otherwise stay.
REQ-020 VERIFY: good header increments count; count reaching g_lock_count -> LOCKED; bad header -> HUNT; valid-low cycles ignored.
REQ-021 LOCKED: bad header increments bad count, good header clears it; g_unlock_count consecutive bad -> HUNT.
REQ-022 LOCKED: watchdog counts cycles with data_valid_i low, clears on valid; reaching g_timeout -> HUNT and timeout_o high one cycle.
REQ-023 Only good frames in LOCKED are pushed; the frame that completes locking is not pushed.
REQ-024 Sequence: each pushed-candidate frame whose seq != previous seq + 1 (mod 16) increments seq_err_ob16 and is still pushed; the first frame after entering LOCKED sets the reference only.
REQ-025 Latency: good frame presented at cycle N with FIFO empty -> cmd_valid_o high at cycle N+2.
REQ-026 Handshake: head popped when cmd_valid_o && cmd_ready_i; outputs stable while valid and not ready.
REQ-027 FIFO full with push and no pop: frame dropped, ovf_err_ob16 increments; full with simultaneous pop: push accepted.
REQ-028 Counters saturate at 0xFFFF, never wrap.
REQ-029 Leaving LOCKED does not flush the FIFO; queued commands still drain.

Reset
REQ-030 Reset: state HUNT, all counters 0, FIFO empty, cmd_valid_o 0, locked_o 0, timeout_o 0, data outputs 0.
REQ-031 Reset asserted mid-operation discards queued commands and in-flight frames in the same cycle.

Configuration
REQ-032 Macro MOTOR_FRAME_CHECKSUM_EN defined: checksum-mismatch frames are not pushed, increment chk_err_ob16, count as good header for lock/sequence logic.
REQ-033 Macro undefined: checksum field ignored, chk_err_ob16 tied to 0.

Structure
REQ-034 MCPkg holds motor_frame_t packed struct, MOTOR_FRAME_HEADER (8'hA5) constant and decoder state enum.
REQ-035 FIFO is sub-module motor_cmd_fifo (single clock, synchronous reset, full/empty flags).

Verification
REQ-036 Reset, then 4 valid frames header 0xA5, seq 0..3 -> locked_o high after 4th; 5th frame (seq 4, motor 3, payload 0x12345678) appears on outputs 2 cycles later.
REQ-037 LOCKED, 3 consecutive frames header 0x00 -> HUNT, locked_o low; 2 bad then 1 good -> stays LOCKED.
REQ-038 LOCKED, data_valid_i low 1024 cycles -> timeout_o one-cycle pulse, locked_o low; low 1023 cycles then valid -> no timeout.
REQ-039 cmd_ready_i low, 6 good frames -> 4 queued, ovf_err_ob16 = 2; then ready high -> 4 commands in order.
REQ-040 Seq 5,6,8 -> seq_err_ob16 = 1, all three delivered; with MOTOR_FRAME_CHECKSUM_EN, corrupted checksum -> frame dropped, chk_err_ob16 = 1.
